// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel stage feeding the priority encoder
module deserializer #(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             data_i,
   input  logic             data_val_i,
   output logic [WIDTH-1:0] deser_data_o,
   output logic             deser_data_val_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic             last_bit;

   always_comb begin
      shreg_next = shreg;
      if (MSB_FIRST) begin
         shreg_next = {shreg[WIDTH-2:0], data_i};
      end else begin
         shreg_next = {data_i, shreg[WIDTH-1:1]};
      end
      last_bit = (bit_cnt == CW'(WIDTH - 1));
   end

   // The output word is taken from shreg_next so the final bit is included
   // on the same edge that completes the word.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         bit_cnt          <= '0;
         shreg            <= '0;
         deser_data_o     <= '0;
         deser_data_val_o <= 1'b0;
      end else begin
         deser_data_val_o <= 1'b0;
         if (data_val_i) begin
            shreg <= shreg_next;
            if (last_bit) begin
               bit_cnt          <= '0;
               deser_data_o     <= shreg_next;
               deser_data_val_o <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

endmodule
